reduce_pipe: RTL
================

# reduce_pipe

Parametrised, pipelined N-input bit-reduction unit with a selectable operation (AND/OR/XOR/NAND), valid/ready handshake and multi-beat frame accumulation. It generalises the fixed 1-bit wide-AND gate cluster: the input count is a parameter, the operation is runtime-selectable, each tree level is registered, and successive beats of a frame fold into one result. It sits between producer logic that emits N-bit condition vectors and any consumer needing a single registered flag per frame, for example match detect or parity check.

## Interface
- UUID, 0, instance identifier XORed into sub-instance UUIDs
- NAME, "", instance name string
- N, 8, number of input bits reduced per beat; legal range 2..64
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  beat present on in_data
- in_ready  out  1  unit can accept a beat this cycle
- in_data  in  N  bits to reduce
- in_op  in  2  operation: 00 AND, 01 OR, 10 XOR, 11 NAND; sampled only on the first beat of a frame
- in_last  in  1  final beat of the frame
- out_valid  out  1  frame result available
- out_ready  in  1  consumer accepts the result
- out_data  out  1  frame reduction result
- out_beats  out  16  number of beats in the frame, saturating at 65535

## Operation
- Tree: fan-in-3 reduction, L = ceil(log3 N) levels (N=8 gives L=2, N=27 gives L=3). Each level is registered and carries a valid bit plus the 2-bit op.
- Padding: a level with fewer than 3 live inputs pads with 1 for AND/NAND and with 0 for OR/XOR.
- NAND: the tree and the accumulator compute AND. Inversion is applied once, when out_data loads.
- Frame op: the `first` flag is set at reset and after each accepted last beat. On an accepted beat with first=1, in_op is latched into frame_op. Every beat of the frame uses frame_op, and in_op on later beats is ignored.
- Accumulator (after tree level L): holds acc, acc_active and a beat counter.
  - First beat out of the tree: acc = partial, count = 1.
  - Later beats: acc = acc op partial, count increments and saturates at 65535.
  - On a last beat: out_data = final result (inverted for NAND), out_beats = count, out_valid = 1, acc_active = 0.
- Stall: stall = out_valid & !out_ready. During a stall every pipeline and accumulator register holds. in_ready = !stall (combinational).
- Output handshake: out_valid clears after an edge where out_valid & out_ready, unless a new last beat completes on that same edge; in that case out_valid stays 1 with new data.
- Reset, including mid-frame: clears all valid bits, acc, acc_active and count, and sets first=1. A partial frame is discarded.
- Reset values: out_valid 0, out_data 0, out_beats 0, in_ready 1.

## Timing
- A beat is accepted on an edge where in_valid & in_ready.
- Latency: a last beat accepted on edge t gives out_valid=1 starting the cycle after edge t+L. That is L+1 edges in total (3 for N=8).
- Throughput: one beat per cycle without backpressure, including back-to-back single-beat frames.
- Backpressure: in_ready falls in the same cycle out_valid & !out_ready holds. Nothing is lost or duplicated, and out_data/out_beats stay stable while stalled.
- Simultaneous events: a last beat accepted together with first=1 forms a one-beat frame. An accept in the same cycle as an output handshake is legal.
- in_valid is ignored while in_ready=0. The bench must not rely on the beat being taken.

## Test plan
- N=8, AND, single-beat frames 0xFF then 0xFE, last=1 -> out_data 1 then 0, out_beats 1; the first result valid 3 edges after accept, in consecutive cycles.
- OR, back-to-back frames 0x00, 0x10, 0x00, 0x80, out_ready=1 -> out_data 0,1,0,1 on four consecutive cycles; in_ready stays 1.
- XOR three-beat frame 0x01, 0x03, 0x07 (last on the third) -> single out_valid pulse, out_data 0 (six ones), out_beats 3; no output on beats 1–2.
- NAND frame: beat 1 op=11 data 0xFF, beat 2 op=01 data 0xFF last -> out_data 0, out_beats 2 (op change ignored).
- Backpressure: a stream of 6 single-beat AND frames with out_ready held low for 5 cycles after the first result -> in_ready low for exactly those cycles, out_data stable, all 6 results delivered in order.
- N=5 AND with data 0x1F -> 1 (padding correct). Assert rst low mid-way through a 3-beat frame -> out_valid 0 and in_ready 1 immediately; the next single-beat frame 0x1F returns 1 with out_beats 1.

Source files
------------

// File: rtl/reduce_pipe.sv
`default_nettype none
// ============================================================================
// Module   : reduce_pipe
// Purpose  : Pipelined N-input bit reduction (AND/OR/XOR/NAND) using a
//            fan-in-3 tree with one register per level. Successive beats of
//            a frame are folded into a single registered result flag.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1   clock, rising edge
//   rst        in   1   asynchronous reset, active low
//   in_valid   in   1   beat present on in_data
//   in_ready   out  1   beat can be accepted this cycle (combinational)
//   in_data    in   N   bits to reduce
//   in_op      in   2   00 AND, 01 OR, 10 XOR, 11 NAND (first beat only)
//   in_last    in   1   final beat of the frame
//   out_valid  out  1   frame result available
//   out_ready  in   1   consumer accepts the result
//   out_data   out  1   frame reduction result
//   out_beats  out  16  beats in the frame, saturating at 65535
// ============================================================================
module reduce_pipe #(
    parameter int    UUID = 0,
    parameter string NAME = "",
    parameter int    N    = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic [1:0]   in_op,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_data,
    output logic [15:0]  out_beats
);

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    // Live width after k fan-in-3 levels.
    function automatic int lvl_width(input int n, input int k);
        int w;
        w = n;
        for (int i = 0; i < k; i++) begin
            w = (w + 2) / 3;
        end
        return w;
    endfunction

    // ceil(log3 n); 64 inputs need 4 levels, so 8 iterations is ample.
    function automatic int num_levels(input int n);
        int w;
        int l;
        w = n;
        l = 0;
        for (int i = 0; i < 8; i++) begin
            if (w > 1) begin
                w = (w + 2) / 3;
                l++;
            end
        end
        return l;
    endfunction

    localparam int LEVELS = num_levels(N);

    if (N < 2 || N > 64) begin : g_n_check
        $error("reduce_pipe %s (uuid %0d): N=%0d outside 2..64", NAME, UUID, N);
    end

    // NAND is carried through the tree and accumulator as AND.
    function automatic logic red3(input logic [1:0] op, input logic a,
                                  input logic b, input logic c);
        logic r;
        case (op)
            OP_OR:   r = a | b | c;
            OP_XOR:  r = a ^ b ^ c;
            default: r = a & b & c;
        endcase
        return r;
    endfunction

    function automatic logic red2(input logic [1:0] op, input logic a, input logic b);
        logic r;
        case (op)
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    // Tree level registers: level k holds the output of reduction level k+1.
    logic [N-1:0]      lvl_data_q [LEVELS];
    logic [N-1:0]      lvl_data_d [LEVELS];
    logic [1:0]        lvl_op_q   [LEVELS];
    logic [1:0]        lvl_op_d   [LEVELS];
    logic [LEVELS-1:0] lvl_vld_q, lvl_vld_d;
    logic [LEVELS-1:0] lvl_last_q, lvl_last_d;

    logic        first_q, first_d;
    logic [1:0]  frame_op_q, frame_op_d;
    logic        acc_q, acc_d;
    logic        acc_active_q, acc_active_d;
    logic [15:0] cnt_q, cnt_d;
    logic        out_valid_q, out_valid_d;
    logic        out_data_q, out_data_d;
    logic [15:0] out_beats_q, out_beats_d;

    logic          stall;
    logic          accept;
    logic [1:0]    beat_op;
    logic [N-1:0]  src_data;
    logic [1:0]    src_op;
    logic          src_vld;
    logic          src_last;
    logic          pad;
    logic [3*N-1:0] ext;
    logic [1:0]    tail_op;
    logic          fold;
    logic [15:0]   cnt_next;

    always_comb begin
        stall    = out_valid_q & ~out_ready;
        in_ready = ~stall;
        accept   = in_valid & ~stall;
        // Later beats of a frame reuse the op latched on the first beat.
        beat_op  = first_q ? in_op : frame_op_q;

        first_d      = first_q;
        frame_op_d   = frame_op_q;
        lvl_vld_d    = lvl_vld_q;
        lvl_last_d   = lvl_last_q;
        acc_d        = acc_q;
        acc_active_d = acc_active_q;
        cnt_d        = cnt_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_beats_d  = out_beats_q;
        src_data     = '0;
        src_op       = OP_AND;
        src_vld      = 1'b0;
        src_last     = 1'b0;
        pad          = 1'b1;
        ext          = '0;
        for (int k = 0; k < LEVELS; k++) begin
            lvl_data_d[k] = lvl_data_q[k];
            lvl_op_d[k]   = lvl_op_q[k];
        end

        if (accept) begin
            if (first_q) begin
                frame_op_d = in_op;
            end
            first_d = in_last;
        end

        if (!stall) begin
            for (int k = 0; k < LEVELS; k++) begin
                if (k == 0) begin
                    src_data = in_data;
                    src_op   = beat_op;
                    src_vld  = accept;
                    src_last = in_last;
                end else begin
                    src_data = lvl_data_q[(k == 0) ? 0 : k - 1];
                    src_op   = lvl_op_q[(k == 0) ? 0 : k - 1];
                    src_vld  = lvl_vld_q[(k == 0) ? 0 : k - 1];
                    src_last = lvl_last_q[(k == 0) ? 0 : k - 1];
                end
                // Missing inputs take the identity element of the operation.
                pad = (src_op == OP_AND) || (src_op == OP_NAND);
                ext = {(3*N){pad}};
                for (int i = 0; i < N; i++) begin
                    if (i < lvl_width(N, k)) begin
                        ext[i] = src_data[i];
                    end
                end
                lvl_data_d[k] = '0;
                for (int j = 0; j < N; j++) begin
                    if (j < lvl_width(N, k + 1)) begin
                        lvl_data_d[k][j] = red3(src_op, ext[3*j], ext[3*j+1], ext[3*j+2]);
                    end
                end
                lvl_vld_d[k]  = src_vld;
                lvl_last_d[k] = src_last;
                lvl_op_d[k]   = src_op;
            end
        end

        tail_op  = lvl_op_q[LEVELS-1];
        fold     = acc_active_q ? red2(tail_op, acc_q, lvl_data_q[LEVELS-1][0])
                                : lvl_data_q[LEVELS-1][0];
        cnt_next = acc_active_q ? ((cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1)
                                : 16'd1;

        if (!stall) begin
            // Not stalled means any pending result is consumed on this edge.
            out_valid_d = 1'b0;
            if (lvl_vld_q[LEVELS-1]) begin
                if (lvl_last_q[LEVELS-1]) begin
                    out_valid_d  = 1'b1;
                    out_data_d   = (tail_op == OP_NAND) ? ~fold : fold;
                    out_beats_d  = cnt_next;
                    acc_d        = 1'b0;
                    acc_active_d = 1'b0;
                    cnt_d        = 16'd0;
                end else begin
                    acc_d        = fold;
                    acc_active_d = 1'b1;
                    cnt_d        = cnt_next;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < LEVELS; k++) begin
                lvl_data_q[k] <= '0;
                lvl_op_q[k]   <= OP_AND;
            end
            lvl_vld_q    <= '0;
            lvl_last_q   <= '0;
            first_q      <= 1'b1;
            frame_op_q   <= OP_AND;
            acc_q        <= 1'b0;
            acc_active_q <= 1'b0;
            cnt_q        <= 16'd0;
            out_valid_q  <= 1'b0;
            out_data_q   <= 1'b0;
            out_beats_q  <= 16'd0;
        end else begin
            for (int k = 0; k < LEVELS; k++) begin
                lvl_data_q[k] <= lvl_data_d[k];
                lvl_op_q[k]   <= lvl_op_d[k];
            end
            lvl_vld_q    <= lvl_vld_d;
            lvl_last_q   <= lvl_last_d;
            first_q      <= first_d;
            frame_op_q   <= frame_op_d;
            acc_q        <= acc_d;
            acc_active_q <= acc_active_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_beats_q  <= out_beats_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_beats = out_beats_q;

endmodule
`default_nettype wire
